// File: rtl/window3x3_gen_pkg.sv
// ----------------------------------------------------------------------------
// window_pkg : shared kernel geometry for the 3x3 window former.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package window_pkg;

  localparam int KSIZE = 3;
  localparam int NTAPS = KSIZE * KSIZE;

  function automatic int tap_idx(input int i, input int j);
    return KSIZE * i + j;
  endfunction

endpackage

`default_nettype wire

// File: rtl/window3x3_gen_if.sv
// ----------------------------------------------------------------------------
// window3x3_gen_if : pixel stream in, 3x3 window stream out.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface window3x3_gen_if
  import window_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic                   ivalid;
  logic                   isof;
  logic [WIDTH-1:0]       idata;
  logic                   ovalid;
  logic [NTAPS*WIDTH-1:0] owindow;
  logic                   oframe_end;

  modport master (
    output ivalid,
    output isof,
    output idata,
    input  ovalid,
    input  owindow,
    input  oframe_end
  );

  modport slave (
    input  ivalid,
    input  isof,
    input  idata,
    output ovalid,
    output owindow,
    output oframe_end
  );

endinterface

`default_nettype wire

// File: rtl/window3x3_gen_line_delay_ram.sv
// ----------------------------------------------------------------------------
// line_delay_ram : one-line delay, shared read/write address, async read.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module line_delay_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 640,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              i_we,
  input  wire logic [ADDR_W-1:0] i_addr,
  input  wire logic [WIDTH-1:0]  i_wdata,
  output logic      [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Read returns the entry written one line ago, before this edge overwrites it.
  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/window3x3_gen.sv
// ----------------------------------------------------------------------------
// window3x3_gen : sliding 3x3 neighbourhood former over two line delays.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module window3x3_gen
  import window_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input wire logic        clock,
  input wire logic        reset,
  window3x3_gen_if.slave  bus
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] C_COL_MIN  = COL_W'(KSIZE - 1);
  localparam logic [ROW_W-1:0] C_ROW_MIN  = ROW_W'(KSIZE - 1);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [WIDTH-1:0] r_win [NTAPS];
  logic             r_ovalid;
  logic             r_oframe_end;

  logic             w_sof;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic [WIDTH-1:0] w_l0_rd;
  logic [WIDTH-1:0] w_l1_rd;

  // A qualified start-of-frame forces the current pixel to (0,0).
  assign w_sof = bus.ivalid & bus.isof;
  assign w_col = w_sof ? '0 : r_col;
  assign w_row = w_sof ? '0 : r_row;

  line_delay_ram #(
    .WIDTH (WIDTH),
    .DEPTH (IMG_W),
    .ADDR_W(COL_W)
  ) u_l0 (
    .clk    (clock),
    .i_we   (bus.ivalid),
    .i_addr (w_col),
    .i_wdata(bus.idata),
    .o_rdata(w_l0_rd)
  );

  line_delay_ram #(
    .WIDTH (WIDTH),
    .DEPTH (IMG_W),
    .ADDR_W(COL_W)
  ) u_l1 (
    .clk    (clock),
    .i_we   (bus.ivalid),
    .i_addr (w_col),
    .i_wdata(w_l0_rd),
    .o_rdata(w_l1_rd)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col        <= '0;
      r_row        <= '0;
      r_ovalid     <= 1'b0;
      r_oframe_end <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        r_win[k] <= '0;
      end
    end else if (bus.ivalid) begin
      for (int i = 0; i < KSIZE; i++) begin
        for (int j = 0; j < KSIZE - 1; j++) begin
          r_win[tap_idx(i, j)] <= r_win[tap_idx(i, j + 1)];
        end
      end
      r_win[tap_idx(0, KSIZE - 1)] <= w_l1_rd;
      r_win[tap_idx(1, KSIZE - 1)] <= w_l0_rd;
      r_win[tap_idx(2, KSIZE - 1)] <= bus.idata;

      r_ovalid     <= (w_row >= C_ROW_MIN) && (w_col >= C_COL_MIN);
      r_oframe_end <= (w_row == C_ROW_LAST) && (w_col == C_COL_LAST);

      if (w_col == C_COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row == C_ROW_LAST) ? '0 : w_row + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
    end else begin
      r_ovalid     <= 1'b0;
      r_oframe_end <= 1'b0;
    end
  end

  for (genvar k = 0; k < NTAPS; k++) begin : g_pack
    assign bus.owindow[k*WIDTH +: WIDTH] = r_win[k];
  end

  assign bus.ovalid     = r_ovalid;
  assign bus.oframe_end = r_oframe_end;

endmodule

`default_nettype wire
